logic_analyzer_vga: RTL and testbench



---
 rtl/logic_analyzer_vga_if.sv | 17 +
 rtl/logic_analyzer_vga.sv | 145 ++++++++++++++
 tb/tb_logic_analyzer_vga.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/logic_analyzer_vga_if.sv
// logic_analyzer_vga_if: board pins of the analyzer, probe and key inputs plus the VGA outputs.
interface logic_analyzer_vga_if;
    logic [3:0] signal;
    logic       trigger;
    logic       add_key;
    logic       dec_key;
    logic       sampling_clr_n;
    logic       hsync;
    logic       vsync;
    logic       vga_r;
    logic       vga_g;
    logic       vga_b;
    modport master (output signal, trigger, add_key, dec_key, sampling_clr_n,
                    input hsync, vsync, vga_r, vga_g, vga_b);
    modport slave (input signal, trigger, add_key, dec_key, sampling_clr_n,
                   output hsync, vsync, vga_r, vga_g, vga_b);
endinterface

// File: rtl/logic_analyzer_vga.sv
// logic_analyzer_vga: 4-channel single-shot logic analyzer drawn on a 640x480@60 VGA screen.
// Define KEY_DEBOUNCE_EN to require 20 ms of stable key level before a key edge counts.
module logic_analyzer_vga #(
    parameter int DEPTH = 512,
    parameter int DIV1  = 1,
    parameter int DIV2  = 25,
    parameter int DIV3  = 250
) (
    input logic                 clk,
    input logic                 rst,
    logic_analyzer_vga_if.slave pins
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = $clog2(DIV3 + 1);
    typedef enum logic [1:0] {ARMED, CAPTURE, DONE} state_t;
    state_t        state;
    logic [3:0]    sig_s1, sig_s2;
    logic          trg_s1, trg_s2, trg_d, clr_s1, clr_s2;
    logic [1:0]    key_s1, key_s2, key_lv, key_d;
    logic [1:0]    mode;
    logic [DW-1:0] div, lim;
    logic [AW-1:0] addr, rd_a;
    logic          done, tick, add_ev, dec_ev;
    logic [3:0]    ram [DEPTH];
    logic [3:0]    ram_q, prev_q;
    logic [9:0]    h, v, h_nxt, yt;
    logic          vis, red, grn, blu;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            sig_s1 <= '0;
            sig_s2 <= '0;
            {trg_s1, trg_s2, trg_d} <= '0;
            {clr_s1, clr_s2} <= 2'b11;
            key_s1 <= 2'b11;
            key_s2 <= 2'b11;
            key_d <= 2'b11;
        end else begin
            sig_s1 <= pins.signal;
            sig_s2 <= sig_s1;
            {trg_s1, trg_s2, trg_d} <= {pins.trigger, trg_s1, trg_s2};
            {clr_s1, clr_s2} <= {pins.sampling_clr_n, clr_s1};
            key_s1 <= {pins.dec_key, pins.add_key};
            key_s2 <= key_s1;
            key_d <= key_lv;
        end

`ifdef KEY_DEBOUNCE_EN
    logic [18:0] db_cnt [2];
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            key_lv <= 2'b11;
            db_cnt <= '{default: '0};
        end else
            for (int i = 0; i < 2; i++)
                if (key_s2[i] == key_lv[i]) db_cnt[i] <= '0;
                else if (db_cnt[i] == 19'd499_999) begin
                    key_lv[i] <= key_s2[i];
                    db_cnt[i] <= '0;
                end else db_cnt[i] <= db_cnt[i] + 19'd1;
`else
    assign key_lv = key_s2;
`endif

    assign add_ev = key_d[0] & ~key_lv[0];
    assign dec_ev = key_d[1] & ~key_lv[1];
    assign lim = mode == 2'd1 ? DW'(DIV1 - 1) : mode == 2'd2 ? DW'(DIV2 - 1) : DW'(DIV3 - 1);
    // >= so a mid-capture switch to a faster mode still ticks on the next clock
    assign tick = state == CAPTURE && div >= lim;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= ARMED;
            done <= 1'b0;
            div <= '0;
            addr <= '0;
            mode <= 2'd1;
        end else begin
            if (add_ev && !dec_ev && mode != 2'd3) mode <= mode + 2'd1;
            else if (dec_ev && !add_ev && mode != 2'd1) mode <= mode - 2'd1;
            div <= (state != CAPTURE || tick) ? '0 : div + 1'b1;
            if (!clr_s2) begin
                state <= ARMED;
                done <= 1'b0;
            end else
                case (state)
                    ARMED: if (trg_s2 && !trg_d) begin
                        state <= CAPTURE;
                        addr <= '0;
                    end
                    CAPTURE: if (tick) begin
                        addr <= addr + 1'b1;
                        if (addr == AW'(DEPTH - 1)) begin
                            state <= DONE;
                            done <= 1'b1;
                        end
                    end
                    default: ;
                endcase
        end

    // Read one column ahead so the sample for the current column is ready at the pixel register
    assign h_nxt = h == 10'd799 ? '0 : h + 10'd1;
    assign rd_a = AW'(h_nxt - 10'd64);

    always_ff @(posedge clk) begin
        if (tick && clr_s2) ram[addr] <= sig_s2;
        ram_q <= ram[rd_a];
        prev_q <= ram_q;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            h <= '0;
            v <= '0;
        end else begin
            h <= h_nxt;
            if (h == 10'd799) v <= v == 10'd524 ? '0 : v + 10'd1;
        end

    always_comb begin
        yt = '0;
        grn = 1'b0;
        for (int k = 0; k < 4; k++) begin
            yt = 10'(40 + 100 * k);
            if (v >= yt && v <= yt + 10'd80 && (ram_q[k] != prev_q[k] ||
                (v == yt && ram_q[k]) || (v == yt + 10'd80 && !ram_q[k]))) grn = 1'b1;
        end
        grn = grn && done && h >= 10'd64 && h <= 10'd575;
    end

    assign vis = h < 10'd640 && v < 10'd480;
    assign red = done && h == 10'd64 && v >= 10'd40 && v <= 10'd440;
    assign blu = ((h == 10'd63 || h == 10'd576) && v >= 10'd39 && v <= 10'd440) ||
                 ((v == 10'd39 || v == 10'd440) && h >= 10'd63 && h <= 10'd576);

    always_ff @(posedge clk or posedge rst)
        if (rst) {pins.hsync, pins.vsync, pins.vga_r, pins.vga_g, pins.vga_b} <= 5'b11000;
        else begin
            pins.hsync <= !(h >= 10'd656 && h <= 10'd751);
            pins.vsync <= !(v == 10'd490 || v == 10'd491);
            {pins.vga_r, pins.vga_g, pins.vga_b} <= !vis ? 3'b000 : red ? 3'b100 :
                                                    grn ? 3'b010 : blu ? 3'b001 : 3'b000;
        end
endmodule

// File: tb/tb_logic_analyzer_vga.sv
// tb_logic_analyzer_vga: randomized capture/display scenarios checked against a pixel and sample model.
module tb_logic_analyzer_vga;
    localparam int D1 = 1;
    localparam int D2 = 3;
    localparam int D3 = 7;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int errors = 0;
    int checks = 0;
    int pcount;
    logic [3:0] exp_mem [512];
    logic exp_done = 1'b0;
    int exp_mode = 1;

    logic_analyzer_vga_if pins();
    logic_analyzer_vga #(.DEPTH(512), .DIV1(D1), .DIV2(D2), .DIV3(D3)) dut (
        .clk(clk), .rst(rst), .pins(pins.slave));

    always #20 clk = ~clk;

    // Clocks since reset release; after clock m the outputs show pixel m-1 of the raster
    always @(posedge clk or posedge rst)
        if (rst) pcount <= 0;
        else pcount <= pcount + 1;

    function automatic logic [2:0] pix(int x, int y);
        logic r, g, b, s, p;
        if (x >= 640 || y >= 480) return 3'b000;
        r = exp_done && x == 64 && y >= 40 && y <= 440;
        g = 1'b0;
        if (exp_done && x >= 64 && x <= 575)
            for (int k = 0; k < 4; k++) begin
                int yt;
                yt = 40 + 100 * k;
                s = exp_mem[x - 64][k];
                p = (x == 64) ? s : exp_mem[x - 65][k];
                if ((y == yt && s) || (y == yt + 80 && !s) || (y >= yt && y <= yt + 80 && s != p)) g = 1'b1;
            end
        b = ((x == 63 || x == 576) && y >= 39 && y <= 440) || ((y == 39 || y == 440) && x >= 63 && x <= 576);
        return r ? 3'b100 : g ? 3'b010 : b ? 3'b001 : 3'b000;
    endfunction

    // Sample i is the pin value driven d*(i+1) clocks after the trigger pin is driven high
    task automatic do_capture(input int d, output int n);
        logic [3:0] vals [$];
        pins.trigger = 1'b0;
        repeat (4) @(negedge clk);
        pins.trigger = 1'b1;
        pins.signal = 4'($urandom);
        vals.push_back(pins.signal);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            pins.signal = 4'($urandom);
            vals.push_back(pins.signal);
        end while (!dut.done && n < 512 * d + 100);
        for (int i = 0; i < 512; i++) exp_mem[i] = vals[d * (i + 1)];
        exp_done = 1'b1;
        pins.trigger = 1'b0;
    endtask

    task automatic do_clear();
        pins.sampling_clr_n = 1'b0;
        repeat (5) @(negedge clk);
        pins.sampling_clr_n = 1'b1;
        exp_done = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_key(input logic add, input logic dec);
        pins.add_key = !add;
        pins.dec_key = !dec;
        repeat (4) @(negedge clk);
        pins.add_key = 1'b1;
        pins.dec_key = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        int p, x, fall1, fall2, lows;
        logic hprev;
        fall1 = -1;
        fall2 = -1;
        lows = 0;
        hprev = 1'b1;
        rst = 1'b1;
        pins.signal = '0;
        pins.trigger = 1'b0;
        pins.add_key = 1'b1;
        pins.dec_key = 1'b1;
        pins.sampling_clr_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if ({pins.hsync, pins.vsync, pins.vga_r, pins.vga_g, pins.vga_b} !== 5'b11000) begin
            errors++;
            $display("FAIL reset_outputs got %b want 11000", {pins.hsync, pins.vsync, pins.vga_r, pins.vga_g, pins.vga_b});
        end
        checks++;
        if (dut.done !== 1'b0 || dut.mode !== 2'd1) begin
            errors++;
            $display("FAIL reset_state done=%b mode=%0d want done=0 mode=1", dut.done, dut.mode);
        end
        rst = 1'b0;
        for (int c = 0; c < 1700; c++) begin
            @(negedge clk);
            p = pcount - 1;
            x = p % 800;
            checks++;
            if (pins.hsync !== !(x >= 656 && x <= 751) || pins.vsync !== 1'b1 ||
                {pins.vga_r, pins.vga_g, pins.vga_b} !== 3'b000) begin
                errors++;
                $display("FAIL idle_raster p=%0d hs=%b vs=%b rgb=%b want hs=%b vs=1 rgb=000",
                         p, pins.hsync, pins.vsync, {pins.vga_r, pins.vga_g, pins.vga_b}, !(x >= 656 && x <= 751));
            end
            if (hprev && !pins.hsync) begin
                if (fall1 < 0) fall1 = c;
                else if (fall2 < 0) fall2 = c;
            end
            if (!pins.hsync && fall1 >= 0 && fall2 < 0) lows++;
            hprev = pins.hsync;
        end
        checks++;
        if (fall2 - fall1 != 800) begin
            errors++;
            $display("FAIL hsync_period got %0d want 800", fall2 - fall1);
        end
        checks++;
        if (lows != 96) begin
            errors++;
            $display("FAIL hsync_width got %0d want 96", lows);
        end
    endtask

    task automatic test_capture_mode1();
        int n;
        do_capture(D1, n);
        checks++;
        if (n != 3 + 512 * D1) begin
            errors++;
            $display("FAIL mode1_duration got %0d want %0d", n, 3 + 512 * D1);
        end
        for (int i = 0; i < 512; i++) begin
            checks++;
            if (dut.ram[i] !== exp_mem[i]) begin
                errors++;
                $display("FAIL mode1_ram[%0d] got %h want %h", i, dut.ram[i], exp_mem[i]);
            end
        end
    endtask

    task automatic test_display();
        int p, x, y, w;
        w = 39 * 800 - (pcount - 1);
        checks++;
        if (w < 0) begin
            errors++;
            $display("FAIL display_start raster at %0d already past %0d", pcount - 1, 39 * 800);
        end else begin
            repeat (w) @(negedge clk);
            for (int c = 0; c < 2400; c++) begin
                p = pcount - 1;
                x = p % 800;
                y = (p / 800) % 525;
                checks++;
                if ({pins.vga_r, pins.vga_g, pins.vga_b} !== pix(x, y) || pins.hsync !== !(x >= 656 && x <= 751)) begin
                    errors++;
                    $display("FAIL display x=%0d y=%0d rgb=%b hs=%b want rgb=%b", x, y,
                             {pins.vga_r, pins.vga_g, pins.vga_b}, pins.hsync, pix(x, y));
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_trigger_in_done();
        int p, x, y;
        for (int i = 0; i < 20; i++) begin
            pins.trigger = ~pins.trigger;
            pins.signal = 4'($urandom);
            repeat (2) @(negedge clk);
        end
        pins.trigger = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (dut.done !== 1'b1) begin
            errors++;
            $display("FAIL done_hold got %b want 1", dut.done);
        end
        for (int i = 0; i < 512; i++) begin
            checks++;
            if (dut.ram[i] !== exp_mem[i]) begin
                errors++;
                $display("FAIL done_ram[%0d] got %h want %h", i, dut.ram[i], exp_mem[i]);
            end
        end
        repeat (800 - (pcount - 1) % 800) @(negedge clk);
        for (int c = 0; c < 800; c++) begin
            p = pcount - 1;
            x = p % 800;
            y = (p / 800) % 525;
            checks++;
            if ({pins.vga_r, pins.vga_g, pins.vga_b} !== pix(x, y)) begin
                errors++;
                $display("FAIL done_line x=%0d y=%0d rgb=%b want %b", x, y, {pins.vga_r, pins.vga_g, pins.vga_b}, pix(x, y));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_clear();
        int p, x, y, n;
        do_clear();
        checks++;
        if (dut.done !== 1'b0) begin
            errors++;
            $display("FAIL clear_done got %b want 0", dut.done);
        end
        pins.trigger = 1'b0;
        repeat (600) @(negedge clk);
        checks++;
        if (dut.done !== 1'b0) begin
            errors++;
            $display("FAIL falling_trigger done=%b want 0", dut.done);
        end
        repeat (800 - (pcount - 1) % 800) @(negedge clk);
        for (int c = 0; c < 800; c++) begin
            p = pcount - 1;
            x = p % 800;
            y = (p / 800) % 525;
            checks++;
            if ({pins.vga_r, pins.vga_g, pins.vga_b} !== pix(x, y)) begin
                errors++;
                $display("FAIL cleared_line x=%0d y=%0d rgb=%b want %b", x, y, {pins.vga_r, pins.vga_g, pins.vga_b}, pix(x, y));
            end
            @(negedge clk);
        end
        pins.trigger = 1'b0;
        repeat (4) @(negedge clk);
        pins.trigger = 1'b1;
        repeat (100) @(negedge clk);
        do_clear();
        repeat (600) @(negedge clk);
        checks++;
        if (dut.done !== 1'b0) begin
            errors++;
            $display("FAIL abort_capture done=%b want 0", dut.done);
        end
        do_capture(D1, n);
        checks++;
        if (n != 3 + 512 * D1) begin
            errors++;
            $display("FAIL recapture_duration got %0d want %0d", n, 3 + 512 * D1);
        end
        for (int i = 0; i < 512; i++) begin
            checks++;
            if (dut.ram[i] !== exp_mem[i]) begin
                errors++;
                $display("FAIL recapture_ram[%0d] got %h want %h", i, dut.ram[i], exp_mem[i]);
            end
        end
    endtask

    task automatic test_modes();
        int n;
        for (int i = 0; i < 3; i++) begin
            pulse_key(1'b1, 1'b0);
            exp_mode = exp_mode == 3 ? 3 : exp_mode + 1;
            checks++;
            if (dut.mode !== 2'(exp_mode)) begin
                errors++;
                $display("FAIL add_key_%0d mode=%0d want %0d", i, dut.mode, exp_mode);
            end
        end
        do_clear();
        do_capture(D3, n);
        checks++;
        if (n != 3 + 512 * D3) begin
            errors++;
            $display("FAIL mode3_duration got %0d want %0d", n, 3 + 512 * D3);
        end
        for (int i = 0; i < 512; i++) begin
            checks++;
            if (dut.ram[i] !== exp_mem[i]) begin
                errors++;
                $display("FAIL mode3_ram[%0d] got %h want %h", i, dut.ram[i], exp_mem[i]);
            end
        end
        pulse_key(1'b0, 1'b1);
        exp_mode = 2;
        checks++;
        if (dut.mode !== 2'(exp_mode)) begin
            errors++;
            $display("FAIL dec_key mode=%0d want %0d", dut.mode, exp_mode);
        end
        do_clear();
        do_capture(D2, n);
        checks++;
        if (n != 3 + 512 * D2) begin
            errors++;
            $display("FAIL mode2_duration got %0d want %0d", n, 3 + 512 * D2);
        end
        for (int i = 0; i < 512; i++) begin
            checks++;
            if (dut.ram[i] !== exp_mem[i]) begin
                errors++;
                $display("FAIL mode2_ram[%0d] got %h want %h", i, dut.ram[i], exp_mem[i]);
            end
        end
    endtask

    task automatic test_both_keys();
        pulse_key(1'b1, 1'b1);
        checks++;
        if (dut.mode !== 2'(exp_mode)) begin
            errors++;
            $display("FAIL both_keys mode=%0d want %0d", dut.mode, exp_mode);
        end
    endtask

    task automatic test_reset_mid_capture();
        int n;
        do_clear();
        pins.trigger = 1'b0;
        repeat (4) @(negedge clk);
        pins.trigger = 1'b1;
        repeat (50) @(negedge clk);
        #5;
        pins.trigger = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if ({pins.hsync, pins.vsync, pins.vga_r, pins.vga_g, pins.vga_b} !== 5'b11000 ||
            dut.done !== 1'b0 || dut.mode !== 2'd1) begin
            errors++;
            $display("FAIL async_reset out=%b done=%b mode=%0d want 11000 0 1",
                     {pins.hsync, pins.vsync, pins.vga_r, pins.vga_g, pins.vga_b}, dut.done, dut.mode);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_mode = 1;
        exp_done = 1'b0;
        do_capture(D1, n);
        checks++;
        if (n != 3 + 512 * D1) begin
            errors++;
            $display("FAIL post_reset_duration got %0d want %0d", n, 3 + 512 * D1);
        end
        for (int i = 0; i < 512; i++) begin
            checks++;
            if (dut.ram[i] !== exp_mem[i]) begin
                errors++;
                $display("FAIL post_reset_ram[%0d] got %h want %h", i, dut.ram[i], exp_mem[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_capture_mode1();
        test_display();
        test_trigger_in_done();
        test_clear();
        test_modes();
        test_both_keys();
        test_reset_mid_capture();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
